wb_write_stage: RTL and testbench

// Write-back stage directly upstream of the 16-bit register bank (R0..R7).

---
 rtl/wb_pkg.sv | 17 +
 rtl/wb_fifo.sv | 71 +++++++
 rtl/wb_write_stage.sv | 99 +++++++++
 tb/tb_wb_write_stage.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the write-back stage: default widths, arbiter grant
// encoding and the buffered write entry.
package wb_pkg;

  localparam int unsigned WB_DW   = 16;
  localparam int unsigned WB_AW   = 3;
  localparam int unsigned WB_NREG = 1 << WB_AW;

  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_MEM = 1'b1;

  typedef struct packed {
    logic [WB_AW-1:0] addr;
    logic [WB_DW-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO with occupancy count and flush; Depth must be a
// power of two so the pointers wrap naturally.
module wb_fifo #(
  parameter int unsigned Width = 19,
  parameter int unsigned Depth = 2,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth) + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic            pop_i,
  input  logic            flush_i,
  output logic [Width-1:0] rdata_o,
  output logic [CntW-1:0] count_o,
  output logic            empty_o,
  output logic            full_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(Depth));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Never overflow or underflow, whatever the caller requests.
  assign push_ok = push_i && !full_o && !flush_i;
  assign pop_ok  = pop_i && !empty_o && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/wb_write_stage.sv
// Write-back stage: round-robin arbitration of ALU and load results into a
// small FIFO, drained one entry per cycle as a one-hot register write.
module wb_write_stage
  import wb_pkg::*;
#(
  parameter int unsigned DW    = WB_DW,
  parameter int unsigned AW    = WB_AW,
  parameter int unsigned NREG  = WB_NREG,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [AW-1:0]   alu_addr,
  input  logic [DW-1:0]   alu_data,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic [AW-1:0]   mem_addr,
  input  logic [DW-1:0]   mem_data,
  input  logic            wb_hold,
  input  logic            wb_flush,
  output logic [NREG-1:0] reg_en,
  output logic [DW-1:0]   reg_wdata,
  output logic [CW-1:0]   wb_count,
  output logic            wb_empty
);

  logic [AW+DW-1:0] push_entry, head_entry;
  logic             full, empty, push, pop;
  logic             grant_alu, grant_mem;
  logic             last_grant_q, last_grant_d;

  // Grants depend only on registered occupancy, never on this cycle's pop.
  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    if (rst_b && !full && !wb_flush) begin
      if (alu_valid && mem_valid) begin
        grant_alu = (last_grant_q == SRC_MEM);
        grant_mem = !grant_alu;
      end else begin
        grant_alu = alu_valid;
        grant_mem = mem_valid;
      end
    end
  end

  assign alu_ready  = grant_alu;
  assign mem_ready  = grant_mem;
  assign push       = grant_alu | grant_mem;
  assign push_entry = grant_mem ? {mem_addr, mem_data} : {alu_addr, alu_data};

  always_comb begin
    last_grant_d = last_grant_q;
    if (push) last_grant_d = grant_mem ? SRC_MEM : SRC_ALU;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) last_grant_q <= SRC_MEM;
    else        last_grant_q <= last_grant_d;
  end

  wb_fifo #(
    .Width(AW + DW),
    .Depth(DEPTH)
  ) u_fifo (
    .clk_i  (clk),
    .rst_ni (rst_b),
    .push_i (push),
    .wdata_i(push_entry),
    .pop_i  (pop),
    .flush_i(wb_flush),
    .rdata_o(head_entry),
    .count_o(wb_count),
    .empty_o(empty),
    .full_o (full)
  );

  assign wb_empty = empty;
  assign pop      = !empty && !wb_hold && !wb_flush;

  always_comb begin
    reg_en    = '0;
    reg_wdata = '0;
    if (pop) begin
      reg_en    = NREG'(1) << head_entry[AW+DW-1:DW];
      reg_wdata = head_entry[DW-1:0];
    end
  end

  // A stalled source must present the same result until it is accepted.
  alu_stable_a: assert property (@(posedge clk) disable iff (!rst_b)
    alu_valid && !alu_ready |=> !alu_valid || ($stable(alu_addr) && $stable(alu_data)));
  mem_stable_a: assert property (@(posedge clk) disable iff (!rst_b)
    mem_valid && !mem_ready |=> !mem_valid || ($stable(mem_addr) && $stable(mem_data)));

endmodule

// File: tb/tb_wb_write_stage.sv
// Bench for wb_write_stage: queue-based model checked every cycle, plus
// directed scenarios with literal expectations and a register-bank stand-in.
module tb_wb_write_stage;
  import wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        alu_valid, alu_ready, mem_valid, mem_ready;
  logic [2:0]  alu_addr, mem_addr;
  logic [15:0] alu_data, mem_data;
  logic        wb_hold, wb_flush;
  logic [7:0]  reg_en;
  logic [15:0] reg_wdata;
  logic [1:0]  wb_count;
  logic        wb_empty;

  int n_tests = 0;
  int n_fail  = 0;

  wb_write_stage dut (
    .clk      (clk),
    .rst_b    (rst_b),
    .alu_valid(alu_valid),
    .alu_ready(alu_ready),
    .alu_addr (alu_addr),
    .alu_data (alu_data),
    .mem_valid(mem_valid),
    .mem_ready(mem_ready),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .wb_hold  (wb_hold),
    .wb_flush (wb_flush),
    .reg_en   (reg_en),
    .reg_wdata(reg_wdata),
    .wb_count (wb_count),
    .wb_empty (wb_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Register bank stand-in driven by the DUT outputs.
  logic [15:0] bank [8];
  initial for (int i = 0; i < 8; i++) bank[i] = '0;
  always @(posedge clk) for (int i = 0; i < 8; i++) if (reg_en[i]) bank[i] <= reg_wdata;

  function automatic logic [15:0] rd_bypass(input int r);
    return reg_en[r] ? reg_wdata : bank[r];
  endfunction

  // Model: an in-order queue of accepted writes plus the last granted source.
  wb_entry_t mq[$];
  logic      m_last = SRC_MEM;

  function automatic void model_eval(output logic ar, output logic mr, output logic pop);
    logic open;
    open = rst_b && (mq.size() < 2) && !wb_flush;
    ar   = open && alu_valid && (!mem_valid || m_last == SRC_MEM);
    mr   = open && mem_valid && (!alu_valid || m_last == SRC_ALU);
    pop  = rst_b && (mq.size() > 0) && !wb_hold && !wb_flush;
  endfunction

  always @(posedge clk or negedge rst_b) begin
    logic ar, mr, pop;
    if (!rst_b) begin
      mq.delete();
      m_last = SRC_MEM;
    end else begin
      model_eval(ar, mr, pop);
      if (pop) void'(mq.pop_front());
      if (wb_flush) mq.delete();
      if (ar) begin mq.push_back('{addr: alu_addr, data: alu_data}); m_last = SRC_ALU; end
      if (mr) begin mq.push_back('{addr: mem_addr, data: mem_data}); m_last = SRC_MEM; end
    end
  end

  always @(negedge clk) begin
    logic ar, mr, pop;
    logic [7:0]  e_en;
    logic [15:0] e_wd;
    model_eval(ar, mr, pop);
    e_en = '0;
    e_wd = '0;
    if (pop) begin
      e_en = 8'd1 << mq[0].addr;
      e_wd = mq[0].data;
    end
    chk("alu_ready", {31'd0, alu_ready}, {31'd0, ar});
    chk("mem_ready", {31'd0, mem_ready}, {31'd0, mr});
    chk("reg_en", {24'd0, reg_en}, {24'd0, e_en});
    chk("reg_wdata", {16'd0, reg_wdata}, {16'd0, e_wd});
    chk("wb_count", {30'd0, wb_count}, mq.size());
    chk("wb_empty", {31'd0, wb_empty}, {31'd0, mq.size() == 0});
  end

  // Log of writes actually retired by the DUT.
  wb_entry_t drained[$];
  always @(negedge clk) begin
    if (rst_b && reg_en != 0)
      for (int i = 0; i < 8; i++)
        if (reg_en[i]) drained.push_back('{addr: 3'(i), data: reg_wdata});
  end

  task automatic step(input logic av, input logic [2:0] aa, input logic [15:0] ad,
                      input logic mv, input logic [2:0] ma, input logic [15:0] md,
                      input logic hold, input logic flush);
    @(posedge clk);
    #1;
    alu_valid = av; alu_addr = aa; alu_data = ad;
    mem_valid = mv; mem_addr = ma; mem_data = md;
    wb_hold = hold; wb_flush = flush;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int na, nm;
    wb_entry_t exp_order[6];
    rst_b = 1'b0;
    alu_valid = 0; alu_addr = 0; alu_data = 0;
    mem_valid = 0; mem_addr = 0; mem_data = 0;
    wb_hold = 0; wb_flush = 0;
    repeat (2) @(posedge clk);
    #1 rst_b = 1'b1;

    // Tie: both valid every cycle, grants alternate starting with ALU.
    drained.delete();
    na = 0; nm = 0;
    for (int i = 0; i < 6; i++) begin
      step(1, 3'd1, 16'h0001 + 16'(na), 1, 3'd2, 16'h8000 + 16'(nm), 0, 0);
      @(negedge clk);
      if (i == 0) chk("tie_first_alu", {31'd0, alu_ready}, 32'd1);
      if (i == 1) chk("tie_second_mem", {31'd0, mem_ready}, 32'd1);
      if (alu_ready) na++;
      if (mem_ready) nm++;
    end
    idle(3);
    exp_order = '{'{3'd1, 16'h0001}, '{3'd2, 16'h8000}, '{3'd1, 16'h0002},
                  '{3'd2, 16'h8001}, '{3'd1, 16'h0003}, '{3'd2, 16'h8002}};
    chk("tie_drain_count", drained.size(), 32'd6);
    for (int i = 0; i < 6 && i < drained.size(); i++)
      chk("tie_drain_order", {13'd0, drained[i]}, {13'd0, exp_order[i]});

    // ALU only: one-cycle latency, bypass visible in the write cycle.
    step(1, 3'd3, 16'hA5A5, 0, 0, 0, 0, 0);
    idle(1);
    @(negedge clk);
    chk("alu_only_en", {24'd0, reg_en}, 32'h08);
    chk("alu_only_wdata", {16'd0, reg_wdata}, 32'hA5A5);
    chk("alu_only_bypass", {16'd0, rd_bypass(3)}, 32'hA5A5);
    idle(1);
    @(negedge clk);
    chk("alu_only_pulse", {24'd0, reg_en}, 32'h0);
    chk("alu_only_r3", {16'd0, bank[3]}, 32'hA5A5);

    // Hold until full, then release: ready stays low while full.
    step(1, 3'd4, 16'h0444, 0, 0, 0, 1, 0);
    step(1, 3'd6, 16'h0666, 0, 0, 0, 1, 0);
    step(1, 3'd7, 16'h0777, 1, 3'd0, 16'h0AAA, 1, 0);
    @(negedge clk);
    chk("full_count", {30'd0, wb_count}, 32'd2);
    chk("full_alu_ready", {31'd0, alu_ready}, 32'd0);
    chk("full_mem_ready", {31'd0, mem_ready}, 32'd0);
    chk("full_hold_en", {24'd0, reg_en}, 32'h0);
    step(1, 3'd7, 16'h0777, 1, 3'd0, 16'h0AAA, 0, 0);
    @(negedge clk);
    chk("release_en0", {24'd0, reg_en}, 32'h10);
    chk("release_ready", {30'd0, alu_ready, mem_ready}, 32'd0);
    step(1, 3'd7, 16'h0777, 1, 3'd0, 16'h0AAA, 0, 0);
    @(negedge clk);
    chk("release_en1", {24'd0, reg_en}, 32'h40);
    chk("release_mem_rr", {30'd0, alu_ready, mem_ready}, 32'd1);
    step(1, 3'd7, 16'h0777, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("release_en2", {24'd0, reg_en}, 32'h01);
    idle(1);
    @(negedge clk);
    chk("release_en3", {24'd0, reg_en}, 32'h80);
    chk("release_wd3", {16'd0, reg_wdata}, 32'h0777);
    idle(1);

    // Same register twice: later acceptance wins.
    step(1, 3'd5, 16'h1111, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 3'd5, 16'h2222, 0, 0);
    idle(3);
    chk("same_reg_r5", {16'd0, bank[5]}, 32'h2222);

    // Flush with two buffered entries and a valid ALU result.
    step(1, 3'd1, 16'h0BAD, 0, 0, 0, 1, 0);
    step(1, 3'd2, 16'h0BEE, 0, 0, 0, 1, 0);
    step(1, 3'd3, 16'h0CCC, 0, 0, 0, 0, 1);
    @(negedge clk);
    chk("flush_alu_ready", {31'd0, alu_ready}, 32'd0);
    chk("flush_en", {24'd0, reg_en}, 32'h0);
    idle(1);
    @(negedge clk);
    chk("flush_count", {30'd0, wb_count}, 32'd0);
    chk("flush_empty", {31'd0, wb_empty}, 32'd1);
    idle(2);
    chk("flush_r1", {16'd0, bank[1]}, 32'h0003);
    chk("flush_r2", {16'd0, bank[2]}, 32'h8002);

    // Asynchronous reset with two buffered entries.
    step(1, 3'd4, 16'h0123, 0, 0, 0, 1, 0);
    step(1, 3'd5, 16'h0456, 0, 0, 0, 1, 0);
    step(1, 3'd6, 16'h0789, 0, 0, 0, 1, 0);
    #2 rst_b = 1'b0;
    #1;
    chk("rst_en", {24'd0, reg_en}, 32'h0);
    chk("rst_count", {30'd0, wb_count}, 32'd0);
    chk("rst_readys", {30'd0, alu_ready, mem_ready}, 32'd0);
    @(posedge clk);
    #1;
    alu_valid = 0; wb_hold = 0;
    @(posedge clk);
    #1 rst_b = 1'b1;
    idle(3);
    chk("rst_r4", {16'd0, bank[4]}, 32'h0444);
    chk("rst_r5", {16'd0, bank[5]}, 32'h2222);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
